// File: rtl/jk_cmd_sequencer.sv
// Command front end for a J-K flip-flop: buffers {op,rpt} commands in a small FIFO,
// drives j/k for rpt+1 cycles each, and checks the fed-back q against a shadow model.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int RPT_W = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RPT_W-1:0] cmd_rpt,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             exp_q,
  output logic             busy,
  output logic [CNT_W-1:0] level,
  output logic             mismatch,
  input  logic             clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [RPT_W-1:0] rpt;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  state_t           state_q, state_d;
  logic [1:0]       jk_q, jk_d;
  logic [RPT_W-1:0] rem_q, rem_d;
  logic             shadow_q, shadow_d;
  logic             err_q, err_d;

  logic [AW:0] occ;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  entry_t      head;

  // Extra pointer MSB separates full (difference == DEPTH) from empty.
  assign occ   = wr_ptr_q - rd_ptr_q;
  assign full  = (occ == FULL_LVL);
  assign empty = (occ == '0);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    jk_d     = jk_q;
    rem_d    = rem_q;
    pop      = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{op: cmd_op, rpt: cmd_rpt};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        jk_d = 2'b00;
        if (!empty) pop = 1'b1;
      end
      ISSUE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          jk_d    = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        jk_d    = 2'b00;
        state_d = IDLE;
      end
    endcase

    // Loading on the completing edge keeps consecutive commands bubble-free.
    if (pop) begin
      jk_d     = head.op;
      rem_d    = head.rpt;
      state_d  = ISSUE;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    case (jk_q)
      2'b01:   shadow_d = 1'b0;
      2'b10:   shadow_d = 1'b1;
      2'b11:   shadow_d = ~shadow_q;
      default: shadow_d = shadow_q;
    endcase
    err_d = (err_q && !clr_err) || (q_fb != shadow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      jk_q     <= 2'b00;
      rem_q    <= '0;
      shadow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      jk_q     <= jk_d;
      rem_q    <= rem_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = !full;
  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign exp_q     = shadow_q;
  assign busy      = (state_q == ISSUE);
  assign level     = CNT_W'(occ);
  assign mismatch  = err_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural J-K flip-flop on q_fb
// and a force hook used to provoke shadow-model mismatches.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int RPT_W = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [RPT_W-1:0] cmd_rpt;
  logic             j, k;
  logic             q_fb;
  logic             exp_q;
  logic             busy;
  logic [CNT_W-1:0] level;
  logic             mismatch;
  logic             clr_err;

  logic ff_q;
  logic force_en;
  logic force_val;

  int vectors  = 0;
  int miscomps = 0;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rpt   (cmd_rpt),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .exp_q     (exp_q),
    .busy      (busy),
    .level     (level),
    .mismatch  (mismatch),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // The flip-flop being commanded; force lets the bench inject a bad q.
  always @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_fb = force_en ? force_val : ff_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [RPT_W-1:0] rpt);
    cmd_valid = v;
    cmd_op    = op;
    cmd_rpt   = rpt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscomps++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  logic [2:0] jkb_tbl [7];
  logic       tog_tbl [4];

  initial begin
    rst = 1'b1; clr_err = 1'b0; force_en = 1'b0; force_val = 1'b0;
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick(); tick();
    checkOutput("rst_j",     32'(j), 0);
    checkOutput("rst_k",     32'(k), 0);
    checkOutput("rst_expq",  32'(exp_q), 0);
    checkOutput("rst_busy",  32'(busy), 0);
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_mism",  32'(mismatch), 0);
    checkOutput("rst_ready", 32'(cmd_ready), 1);
    rst = 1'b0;

    // Single set, rpt=0
    applyStimulus(1'b1, 2'b10, 4'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    checkOutput("set_level_acc", 32'(level), 1);
    checkOutput("set_j_acc",     32'(j), 0);
    tick();
    checkOutput("set_jk_on",  32'({j, k}), 32'(2'b10));
    checkOutput("set_busy",   32'(busy), 1);
    checkOutput("set_level0", 32'(level), 0);
    tick();
    checkOutput("set_jk_off", 32'({j, k}), 0);
    checkOutput("set_busy_off", 32'(busy), 0);
    checkOutput("set_expq",   32'(exp_q), 1);
    checkOutput("set_qfb",    32'(q_fb), 1);
    tick();
    checkOutput("set_mism",   32'(mismatch), 0);

    // Clear back to q=0, then toggle rpt=3
    applyStimulus(1'b1, 2'b01, 4'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick(); tick();
    checkOutput("clr_expq", 32'(exp_q), 0);
    applyStimulus(1'b1, 2'b11, 4'd3);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick();
    checkOutput("tog_jk",   32'({j, k}), 32'(2'b11));
    checkOutput("tog_busy0", 32'(busy), 1);
    checkOutput("tog_expq0", 32'(exp_q), 0);
    tog_tbl = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("tog_expq%0d", i + 1), 32'(exp_q), 32'(tog_tbl[i]));
      checkOutput($sformatf("tog_busy%0d", i + 1), 32'(busy), (i < 3) ? 1 : 0);
    end
    checkOutput("tog_end_jk", 32'({j, k}), 0);

    // Back-to-back and full: a long hold occupies the issuer while the FIFO fills
    applyStimulus(1'b1, 2'b00, 4'd7); tick();
    checkOutput("b2b_level1", 32'(level), 1);
    applyStimulus(1'b1, 2'b10, 4'd1); tick();
    applyStimulus(1'b1, 2'b01, 4'd0); tick();
    applyStimulus(1'b1, 2'b11, 4'd2); tick();
    applyStimulus(1'b1, 2'b00, 4'd0); tick();
    checkOutput("b2b_full_level", 32'(level), 4);
    checkOutput("b2b_full_ready", 32'(cmd_ready), 0);
    applyStimulus(1'b1, 2'b10, 4'd0);
    tick(); tick(); tick(); tick();
    checkOutput("b2b_held_level", 32'(level), 4);
    checkOutput("b2b_held_ready", 32'(cmd_ready), 0);
    tick();
    checkOutput("b2b_pop_level", 32'(level), 3);
    checkOutput("b2b_pop_ready", 32'(cmd_ready), 1);
    checkOutput("b2b_c1_jk",     32'({j, k}), 32'(2'b10));
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    checkOutput("b2b_c5_level", 32'(level), 4);
    jkb_tbl = '{3'b011, 3'b111, 3'b111, 3'b111, 3'b001, 3'b101, 3'b000};
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("b2b_jkbusy%0d", i), 32'({j, k, busy}), 32'(jkb_tbl[i]));
    end
    checkOutput("b2b_expq",  32'(exp_q), 1);
    checkOutput("b2b_level", 32'(level), 0);
    checkOutput("b2b_mism",  32'(mismatch), 0);

    // Simultaneous push/pop at level 2
    applyStimulus(1'b1, 2'b10, 4'd1); tick();
    applyStimulus(1'b1, 2'b01, 4'd0); tick();
    applyStimulus(1'b1, 2'b11, 4'd0); tick();
    checkOutput("pp_level_pre", 32'(level), 2);
    applyStimulus(1'b1, 2'b10, 4'd0); tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    checkOutput("pp_level", 32'(level), 2);
    checkOutput("pp_jk",    32'({j, k}), 32'(2'b01));
    checkOutput("pp_busy",  32'(busy), 1);
    tick();
    checkOutput("pp_next_jk", 32'({j, k}), 32'(2'b11));
    tick(); tick();
    checkOutput("pp_done_busy", 32'(busy), 0);
    checkOutput("pp_done_expq", 32'(exp_q), 1);

    // Mismatch: bring shadow to 0, then inject q=1
    applyStimulus(1'b1, 2'b01, 4'd0); tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick(); tick();
    checkOutput("mm_expq0", 32'(exp_q), 0);
    checkOutput("mm_pre",   32'(mismatch), 0);
    force_en = 1'b1; force_val = 1'b1;
    tick();
    force_en = 1'b0;
    checkOutput("mm_set", 32'(mismatch), 1);
    tick();
    checkOutput("mm_sticky", 32'(mismatch), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("mm_clear", 32'(mismatch), 0);
    clr_err = 1'b1; force_en = 1'b1;
    tick();
    clr_err = 1'b0; force_en = 1'b0;
    checkOutput("mm_set_wins", 32'(mismatch), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("mm_clear2", 32'(mismatch), 0);

    // Reset during an active toggle with three queued entries
    applyStimulus(1'b1, 2'b11, 4'd5); tick();
    applyStimulus(1'b1, 2'b10, 4'd0); tick();
    checkOutput("rr_active_jk", 32'({j, k}), 32'(2'b11));
    applyStimulus(1'b1, 2'b01, 4'd0); tick();
    applyStimulus(1'b1, 2'b11, 4'd1); tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    checkOutput("rr_level3", 32'(level), 3);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rr_jk",    32'({j, k}), 0);
    checkOutput("rr_level", 32'(level), 0);
    checkOutput("rr_busy",  32'(busy), 0);
    checkOutput("rr_expq",  32'(exp_q), 0);
    checkOutput("rr_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("rr_quiet%0d", i), 32'({j, k, busy}), 0);
    end
    checkOutput("rr_mism", 32'(mismatch), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end

endmodule
